// File: rtl/reset_release_seq_pkg.sv
// Shared types and constants for the ordered reset-release sequencer.
//   NUM_STAGES : number of downstream reset domains
//   TIMER_W    : width of the shared hold/timeout timer
//   rr_state_e : sequencer FSM states
//   tmr_ctl_t  : command word driven into rr_timer each cycle
package reset_seq_pkg;
  localparam int NUM_STAGES = 4;
  localparam int TIMER_W    = 8;
  localparam int STAGE_W    = 2;

  typedef enum logic [2:0] {
    WAIT_STB,
    HOLD,
    WAIT_ACK,
    DONE,
    ERROR
  } rr_state_e;

  typedef enum logic [1:0] {
    TMR_IDLE,
    TMR_LOAD,
    TMR_INC,
    TMR_DEC
  } tmr_op_e;

  typedef struct packed {
    tmr_op_e            op;
    logic [TIMER_W-1:0] val;
  } tmr_ctl_t;
endpackage

// File: rtl/reset_release_seq_if.sv
// Strobe/ack/reset bundle between the power-on counter side and the
// reset-release sequencer.
//   strobe    : one-cycle stage strobes from the power-on counter
//   ack       : per-domain "out of reset" levels
//   rst_out_n : per-domain active-low resets
//   done      : all stages acknowledged (sticky)
//   err       : ack timeout seen (sticky)
//   err_stage : stage that timed out
// slave is the sequencer; master is whatever drives strobes and acks.
interface reset_release_seq_if;
  import reset_seq_pkg::*;

  logic [NUM_STAGES-1:0] strobe;
  logic [NUM_STAGES-1:0] ack;
  logic [NUM_STAGES-1:0] rst_out_n;
  logic                  done;
  logic                  err;
  logic [STAGE_W-1:0]    err_stage;

  modport master (
    output strobe, ack,
    input  rst_out_n, done, err, err_stage
  );

  modport slave (
    input  strobe, ack,
    output rst_out_n, done, err, err_stage
  );
endinterface

// File: rtl/reset_release_seq_timer.sv
// rr_timer: 8-bit loadable up/down counter shared by the hold and the
// ack-timeout phases of the sequencer.
//   clk, por_n : clock, async active-low reset (clears the count)
//   ctl        : load / increment / decrement / idle command
//   cnt        : current count
//   is_zero    : cnt == 0
module rr_timer
  import reset_seq_pkg::*;
(
  input  logic               clk,
  input  logic               por_n,
  input  tmr_ctl_t           ctl,
  output logic [TIMER_W-1:0] cnt,
  output logic               is_zero
);
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) begin
      cnt <= '0;
    end else begin
      case (ctl.op)
        TMR_LOAD: cnt <= ctl.val;
        TMR_INC:  cnt <= cnt + 1'b1;
        TMR_DEC:  cnt <= cnt - 1'b1;
        default:  cnt <= cnt;
      endcase
    end
  end

  assign is_zero = (cnt == '0);
endmodule

// File: rtl/reset_release_seq.sv
// reset_release_seq: turns the four power-on counter strobes into an
// ordered, handshaked release of four domain resets. Each stage waits for
// its own strobe, holds HOLD_CYCLES, releases its reset, then waits up to
// ACK_TIMEOUT clocks for the domain ack. A missing ack re-asserts every
// reset and latches err/err_stage.
//   clk   : clock shared with the strobe counter
//   por_n : async active-low power-on reset
//   bus   : strobe/ack in, rst_out_n/done/err/err_stage out (all registered)
module reset_release_seq
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,   // 1..255
  parameter int ACK_TIMEOUT = 16   // 1..255
) (
  input  logic                 clk,
  input  logic                 por_n,
  reset_release_seq_if.slave   bus
);
  localparam logic [TIMER_W-1:0] HOLD_LD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [STAGE_W-1:0] LAST_STG = STAGE_W'(NUM_STAGES - 1);

  rr_state_e             state, state_nxt;
  logic [STAGE_W-1:0]    stage, stage_nxt;
  logic [NUM_STAGES-1:0] rst_q, rst_nxt;
  logic                  done_q, done_nxt;
  logic                  err_q, err_nxt;
  logic [STAGE_W-1:0]    err_stage_q, err_stage_nxt;

  tmr_ctl_t              tmr_ctl;
  logic [TIMER_W-1:0]    tmr_cnt;
  logic                  tmr_zero;

  // Only the current stage's strobe/ack matter; other bits are ignored.
  logic stg_strobe, stg_ack, ack_expired;
  assign stg_strobe  = bus.strobe[stage];
  assign stg_ack     = bus.ack[stage];
  assign ack_expired = (tmr_cnt == TO_LAST);

  rr_timer u_timer (
    .clk     (clk),
    .por_n   (por_n),
    .ctl     (tmr_ctl),
    .cnt     (tmr_cnt),
    .is_zero (tmr_zero)
  );

  // State and output registers
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) begin
      state       <= WAIT_STB;
      stage       <= '0;
      rst_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state       <= state_nxt;
      stage       <= stage_nxt;
      rst_q       <= rst_nxt;
      done_q      <= done_nxt;
      err_q       <= err_nxt;
      err_stage_q <= err_stage_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    case (state)
      WAIT_STB: if (stg_strobe) state_nxt = HOLD;
      HOLD:     if (tmr_zero) state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        // ack has priority over the timeout on the final window edge
        if (stg_ack) begin
          if (stage == LAST_STG) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_STB;
            stage_nxt = stage + 1'b1;
          end
        end else if (ack_expired) begin
          state_nxt = ERROR;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Output and timer control
  always_comb begin
    rst_nxt       = rst_q;
    done_nxt      = done_q;
    err_nxt       = err_q;
    err_stage_nxt = err_stage_q;
    tmr_ctl       = '{op: TMR_IDLE, val: '0};
    case (state)
      WAIT_STB: if (stg_strobe) tmr_ctl = '{op: TMR_LOAD, val: HOLD_LD};
      HOLD: begin
        if (tmr_zero) begin
          rst_nxt[stage] = 1'b1;
          tmr_ctl        = '{op: TMR_LOAD, val: '0};
        end else begin
          tmr_ctl = '{op: TMR_DEC, val: '0};
        end
      end
      WAIT_ACK: begin
        if (stg_ack) begin
          if (stage == LAST_STG) done_nxt = 1'b1;
        end else if (ack_expired) begin
          rst_nxt       = '0;
          err_nxt       = 1'b1;
          err_stage_nxt = stage;
        end else begin
          tmr_ctl = '{op: TMR_INC, val: '0};
        end
      end
      default: ;
    endcase
  end

  assign bus.rst_out_n = rst_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_stage = err_stage_q;
endmodule

// File: tb/tb_reset_release_seq.sv
// Randomized bench for reset_release_seq. Each scenario precomputes the
// strobe stream, derives the expected release/ack/error edges as a
// timeline, then checks every output after every edge. Each scenario ends
// with an asynchronous por_n assertion whose effect is checked at once.
module tb_reset_release_seq;
  localparam int H     = 4;
  localparam int TO    = 16;
  localparam int N     = 1100;
  localparam int BIG   = 1 << 30;
  localparam int NEVER = 99;
  localparam int NONE  = 300;

  logic clk = 1'b0;
  logic por_n = 1'b0;
  reset_release_seq_if bus();

  reset_release_seq #(.HOLD_CYCLES(H), .ACK_TIMEOUT(TO)) dut (
    .clk   (clk),
    .por_n (por_n),
    .bus   (bus)
  );

  always #15 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] strb [N];
  int pos[4], dly[4];
  int T[4], R[4], A[4];
  int E, estage;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe stream: counter starts at 0 on edge 0 and wraps every 256.
  task automatic build(input bit noise, input bit all0);
    for (int t = 0; t < N; t++) begin
      logic [3:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) begin
        if (pos[i] < 256 && (t % 256) == pos[i]) v[i] = 1'b1;
        if (noise && $urandom_range(15) == 0) v[i] = 1'b1;
      end
      if (all0 && t == 0) v = 4'b1111;
      strb[t] = v;
    end
  endtask

  // Timeline model: a stage looks for its strobe from the edge it becomes
  // ready, releases H edges after it, and the first ack edge counted is
  // one after release. An ack later than TO edges is an error at R+TO.
  task automatic model();
    int ready, eff;
    ready = 0;
    E = BIG;
    estage = 0;
    for (int s = 0; s < 4; s++) begin T[s] = BIG; R[s] = BIG; A[s] = BIG; end
    for (int s = 0; s < 4; s++) begin
      for (int t = ready; t < N; t++)
        if (strb[t][s]) begin T[s] = t; break; end
      if (T[s] == BIG) break;
      R[s] = T[s] + H;
      eff = (dly[s] == NEVER) ? NEVER : ((dly[s] < 1) ? 1 : dly[s]);
      if (eff <= TO) begin
        A[s] = R[s] + eff;
        ready = A[s] + 1;
      end else begin
        E = R[s] + TO;
        estage = s;
        break;
      end
    end
  endtask

  task automatic drive(input int k);
    logic [3:0] a;
    for (int i = 0; i < 4; i++)
      a[i] = (dly[i] != NEVER) && (R[i] < BIG) && (k >= R[i] + dly[i]);
    bus.strobe = strb[k];
    bus.ack    = a;
  endtask

  task automatic check_edge(input int sc, input int k);
    logic [3:0] er;
    for (int i = 0; i < 4; i++) er[i] = (k >= R[i]) && (k < E);
    chk($sformatf("s%0d rst_out_n@%0d", sc, k), 32'(bus.rst_out_n), 32'(er));
    chk($sformatf("s%0d done@%0d", sc, k), 32'(bus.done), 32'(k >= A[3]));
    chk($sformatf("s%0d err@%0d", sc, k), 32'(bus.err), 32'(k >= E));
    chk($sformatf("s%0d err_stage@%0d", sc, k), 32'(bus.err_stage),
        (k >= E) ? 32'(estage) : 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " rst_out_n"}, 32'(bus.rst_out_n), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
    chk({tag, " err"}, 32'(bus.err), 32'd0);
    chk({tag, " err_stage"}, 32'(bus.err_stage), 32'd0);
  endtask

  task automatic run_scn(input int sc,
                         input int p0, input int p1, input int p2, input int p3,
                         input int d0, input int d1, input int d2, input int d3,
                         input bit noise, input bit all0, input bit rst_mid);
    int len;
    pos = '{p0, p1, p2, p3};
    dly = '{d0, d1, d2, d3};
    build(noise, all0);
    model();
    if (rst_mid && T[2] < BIG) len = T[2] + 3;     // last check inside stage-2 HOLD
    else if (E < BIG)          len = E + 8;
    else if (A[3] < BIG)       len = A[3] + 8;
    else                       len = 600;
    if (len > N - 2) len = N - 2;

    @(negedge clk);
    por_n = 1'b1;
    drive(0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check_edge(sc, k);
      drive(k + 1);
    end
    // Async reset mid-cycle: outputs must clear without a clock edge.
    #3 por_n = 1'b0;
    #1 check_reset($sformatf("s%0d async", sc));
    bus.strobe = '0;
    bus.ack    = '0;
    @(negedge clk);
  endtask

  initial begin
    bus.strobe = '0;
    bus.ack    = '0;
    #40;
    check_reset("por");

    run_scn(0, 2, 12, 22, 32, 2, 2, 2, 2, 1'b0, 1'b0, 1'b0);             // nominal
    run_scn(1, 2, 12, 22, 32, 2, NEVER, 2, 2, 1'b0, 1'b0, 1'b0);         // stage-1 timeout
    run_scn(2, 2, 12, 40, 70, 2, 2, 16, 2, 1'b0, 1'b0, 1'b0);            // ack on timeout edge
    run_scn(3, 2, 12, 22, 32, 17, 2, 2, 2, 1'b0, 1'b0, 1'b0);            // ack one edge late
    run_scn(4, 2, 10, 30, 50, 12, 2, 2, 2, 1'b0, 1'b0, 1'b0);            // missed strobe
    run_scn(5, NONE, NONE, NONE, NONE, 1, 1, 1, 1, 1'b0, 1'b1, 1'b0);    // 1111 at start
    run_scn(6, 2, 12, 22, 32, 2, 2, 2, 2, 1'b0, 1'b0, 1'b1);             // reset in HOLD 2
    run_scn(7, 2, 12, 22, 32, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);             // ack high at release
    for (int r = 0; r < 8; r++) begin
      int rd[4];
      for (int i = 0; i < 4; i++) begin
        rd[i] = $urandom_range(0, 19);
        if (rd[i] == 19) rd[i] = NEVER;
      end
      run_scn(8 + r, $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255),
              rd[0], rd[1], rd[2], rd[3], 1'b1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
